// File: rtl/snow64_param_instr_cache_if.sv
// Fetch-side and memory-side signals of snow64_param_instr_cache.
// slave: the cache's view. master: the fetch unit / memory arbiter view.
interface snow64_param_instr_cache_if #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH  = 256
);
  logic                   in_req_read_req;
  logic [ADDR_WIDTH-1:0]  in_req_read_addr;
  logic                   out_req_read_valid;
  logic [INSTR_WIDTH-1:0] out_req_read_instr;
  logic                   out_busy;
  logic                   in_flush;
  logic                   out_mem_access_req;
  logic [ADDR_WIDTH-1:0]  out_mem_access_addr;
  logic                   in_mem_access_valid;
  logic [LINE_WIDTH-1:0]  in_mem_access_data;

  modport slave (
    input  in_req_read_req,
    input  in_req_read_addr,
    output out_req_read_valid,
    output out_req_read_instr,
    output out_busy,
    input  in_flush,
    output out_mem_access_req,
    output out_mem_access_addr,
    input  in_mem_access_valid,
    input  in_mem_access_data
  );

  modport master (
    output in_req_read_req,
    output in_req_read_addr,
    input  out_req_read_valid,
    input  out_req_read_instr,
    input  out_busy,
    output in_flush,
    input  out_mem_access_req,
    input  out_mem_access_addr,
    output in_mem_access_valid,
    output in_mem_access_data
  );
endinterface

// File: rtl/snow64_param_instr_cache.sv
// Parametrised direct-mapped read-only instruction cache with line fill and whole-cache flush.
// Define SNOW64_ICACHE_STATS_EN to add the hit/miss counter ports.
module snow64_param_instr_cache #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned NUM_LINES   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  snow64_param_instr_cache_if.slave   bus
`ifdef SNOW64_ICACHE_STATS_EN
  ,
  output logic [31:0]                 out_hit_count,
  output logic [31:0]                 out_miss_count
`else
  // counters absent
`endif
);

  localparam int unsigned OFFS  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned IDX   = $clog2(NUM_LINES);
  localparam int unsigned TAG   = ADDR_WIDTH - OFFS - IDX;
  localparam int unsigned IOFFS = $clog2(INSTR_WIDTH / 8);

  typedef enum logic [1:0] {StIdle, StMissReq, StFill} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic                   fill_we;

  logic [LINE_WIDTH-1:0]  data_arr_q [NUM_LINES];
  logic [TAG-1:0]         tag_arr_q  [NUM_LINES];

  logic [IDX-1:0]         req_idx, fill_idx;
  logic [TAG-1:0]         req_tag, fill_tag;
  logic                   req_hit;

  // Selects the instruction addressed by the offset field; low byte-in-instruction bits are dropped.
  function automatic logic [INSTR_WIDTH-1:0] pick_word(input logic [LINE_WIDTH-1:0] line,
                                                       input logic [ADDR_WIDTH-1:0] a);
    int unsigned w;
    w = 32'(a[OFFS-1:0]) >> IOFFS;
    return INSTR_WIDTH'(line >> (w * INSTR_WIDTH));
  endfunction

  assign req_idx  = bus.in_req_read_addr[OFFS+IDX-1:OFFS];
  assign req_tag  = bus.in_req_read_addr[ADDR_WIDTH-1:OFFS+IDX];
  assign fill_idx = addr_q[OFFS+IDX-1:OFFS];
  assign fill_tag = addr_q[ADDR_WIDTH-1:OFFS+IDX];
  assign req_hit  = valid_q[req_idx] && (tag_arr_q[req_idx] == req_tag);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    rd_valid_d   = 1'b0;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    fill_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_pend_q) begin
          // Deferred flush from a miss; this cycle's request is dropped.
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end else if (bus.in_flush) begin
          valid_d = '0;
        end else if (bus.in_req_read_req) begin
          if (req_hit) begin
            instr_d    = pick_word(data_arr_q[req_idx], bus.in_req_read_addr);
            rd_valid_d = 1'b1;
          end else begin
            addr_d  = bus.in_req_read_addr;
            state_d = StMissReq;
          end
        end
      end
      StMissReq: begin
        if (bus.in_flush) flush_pend_d = 1'b1;
        if (bus.in_mem_access_valid) begin
          fill_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          instr_d           = pick_word(bus.in_mem_access_data, addr_q);
          rd_valid_d        = 1'b1;
          state_d           = StFill;
        end
      end
      StFill: begin
        if (bus.in_flush) flush_pend_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      instr_q      <= '0;
      rd_valid_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      rd_valid_q   <= rd_valid_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  // Data and tag storage carry no reset; the valid flags guard them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_arr_q[fill_idx] <= bus.in_mem_access_data;
      tag_arr_q[fill_idx]  <= fill_tag;
    end
  end

  assign bus.out_req_read_valid  = rd_valid_q;
  assign bus.out_req_read_instr  = instr_q;
  assign bus.out_busy            = (state_q != StIdle) || flush_pend_q;
  assign bus.out_mem_access_req  = (state_q == StMissReq);
  assign bus.out_mem_access_addr = {addr_q[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};

`ifdef SNOW64_ICACHE_STATS_EN
  logic        hit_ev, miss_ev;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign hit_ev  = (state_q == StIdle) && !flush_pend_q && !bus.in_flush &&
                   bus.in_req_read_req && req_hit;
  assign miss_ev = (state_q == StIdle) && (state_d == StMissReq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_ev)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_ev) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign out_hit_count  = hit_cnt_q;
  assign out_miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_snow64_param_instr_cache.sv
// Directed self-checking bench for snow64_param_instr_cache (default geometry).
module tb_snow64_param_instr_cache;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   vcount = 0;
  int   mreq_count = 0;

  logic [255:0] line1, line2, line3;

  snow64_param_instr_cache_if #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .LINE_WIDTH(256)) bus ();

`ifdef SNOW64_ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  snow64_param_instr_cache #(
    .ADDR_WIDTH (64),
    .INSTR_WIDTH(32),
    .LINE_WIDTH (256),
    .NUM_LINES  (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef SNOW64_ICACHE_STATS_EN
    ,
    .out_hit_count (hit_count),
    .out_miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.out_req_read_valid === 1'b1) vcount++;
    if (bus.out_mem_access_req === 1'b1) mreq_count++;
  end

  function automatic logic [255:0] mk_line(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = (i == 0) ? w0 : (i == 1) ? w1 : base + i;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Request a line and answer it on the next cycle, no checking.
  task automatic serve_miss(input logic [63:0] a, input logic [255:0] l);
    bus.in_req_read_req = 1'b1;
    bus.in_req_read_addr = a;
    tick();
    bus.in_req_read_req = 1'b0;
    bus.in_mem_access_valid = 1'b1;
    bus.in_mem_access_data = l;
    tick();
    bus.in_mem_access_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.out_req_read_valid !== 1'b0)
      $display("FAIL reset_valid got=%b want=0", bus.out_req_read_valid); else passed++;
    checks++; if (bus.out_req_read_instr !== 32'h0)
      $display("FAIL reset_instr got=%h want=0", bus.out_req_read_instr); else passed++;
    checks++; if (bus.out_busy !== 1'b0)
      $display("FAIL reset_busy got=%b want=0", bus.out_busy); else passed++;
    checks++; if (bus.out_mem_access_req !== 1'b0)
      $display("FAIL reset_memreq got=%b want=0", bus.out_mem_access_req); else passed++;
    checks++; if (bus.out_mem_access_addr !== 64'h0)
      $display("FAIL reset_memaddr got=%h want=0", bus.out_mem_access_addr); else passed++;
`ifdef SNOW64_ICACHE_STATS_EN
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0)
      $display("FAIL reset_counters got=%0d/%0d want=0/0", hit_count, miss_count); else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cold_miss();
    int v0;
    v0 = vcount;
    bus.in_req_read_req = 1'b1;
    bus.in_req_read_addr = 64'h1004;
    tick();
    bus.in_req_read_req = 1'b0;
    checks++; if (bus.out_mem_access_req !== 1'b1)
      $display("FAIL cold_memreq got=%b want=1", bus.out_mem_access_req); else passed++;
    checks++; if (bus.out_mem_access_addr !== 64'h1000)
      $display("FAIL cold_memaddr got=%h want=1000", bus.out_mem_access_addr); else passed++;
    checks++; if (bus.out_busy !== 1'b1)
      $display("FAIL cold_busy got=%b want=1", bus.out_busy); else passed++;
    tick();
    tick();
    checks++; if (bus.out_mem_access_req !== 1'b1 || bus.out_req_read_valid !== 1'b0)
      $display("FAIL cold_hold got=req%b/v%b want=req1/v0", bus.out_mem_access_req,
               bus.out_req_read_valid); else passed++;
    bus.in_mem_access_valid = 1'b1;
    bus.in_mem_access_data = line1;
    tick();
    bus.in_mem_access_valid = 1'b0;
    checks++; if (bus.out_req_read_valid !== 1'b1 || bus.out_req_read_instr !== 32'hBBBBBBBB)
      $display("FAIL cold_fill got=v%b/%h want=v1/bbbbbbbb", bus.out_req_read_valid,
               bus.out_req_read_instr); else passed++;
    tick();
    checks++; if (bus.out_busy !== 1'b0 || bus.out_req_read_valid !== 1'b0)
      $display("FAIL cold_idle got=busy%b/v%b want=busy0/v0", bus.out_busy,
               bus.out_req_read_valid); else passed++;
    checks++; if (vcount - v0 !== 1)
      $display("FAIL cold_pulses got=%0d want=1", vcount - v0); else passed++;
  endtask

  task automatic test_back_to_back_hits();
    int m0;
    m0 = mreq_count;
    bus.in_req_read_req = 1'b1;
    bus.in_req_read_addr = 64'h1004;
    tick();
    checks++; if (bus.out_req_read_valid !== 1'b1 || bus.out_req_read_instr !== 32'hBBBBBBBB)
      $display("FAIL hit0 got=v%b/%h want=v1/bbbbbbbb", bus.out_req_read_valid,
               bus.out_req_read_instr); else passed++;
    bus.in_req_read_addr = 64'h1000;
    tick();
    bus.in_req_read_req = 1'b0;
    checks++; if (bus.out_req_read_valid !== 1'b1 || bus.out_req_read_instr !== 32'hAAAAAAAA)
      $display("FAIL hit1 got=v%b/%h want=v1/aaaaaaaa", bus.out_req_read_valid,
               bus.out_req_read_instr); else passed++;
    tick();
    checks++; if (bus.out_req_read_valid !== 1'b0 || bus.out_req_read_instr !== 32'hAAAAAAAA)
      $display("FAIL hit_hold got=v%b/%h want=v0/aaaaaaaa", bus.out_req_read_valid,
               bus.out_req_read_instr); else passed++;
    checks++; if (mreq_count - m0 !== 0)
      $display("FAIL hit_nomemreq got=%0d want=0", mreq_count - m0); else passed++;
  endtask

  task automatic test_conflict();
    bus.in_req_read_req = 1'b1;
    bus.in_req_read_addr = 64'h1404;
    tick();
    bus.in_req_read_req = 1'b0;
    checks++; if (bus.out_mem_access_req !== 1'b1 || bus.out_mem_access_addr !== 64'h1400)
      $display("FAIL conf_miss got=req%b/%h want=req1/1400", bus.out_mem_access_req,
               bus.out_mem_access_addr); else passed++;
    bus.in_mem_access_valid = 1'b1;
    bus.in_mem_access_data = line2;
    tick();
    bus.in_mem_access_valid = 1'b0;
    checks++; if (bus.out_req_read_instr !== 32'hCCCCCCCC)
      $display("FAIL conf_fill got=%h want=cccccccc", bus.out_req_read_instr); else passed++;
    tick();
    bus.in_req_read_req = 1'b1;
    bus.in_req_read_addr = 64'h1004;
    tick();
    bus.in_req_read_req = 1'b0;
    checks++; if (bus.out_mem_access_req !== 1'b1 || bus.out_mem_access_addr !== 64'h1000)
      $display("FAIL conf_remiss got=req%b/%h want=req1/1000", bus.out_mem_access_req,
               bus.out_mem_access_addr); else passed++;
    bus.in_mem_access_valid = 1'b1;
    bus.in_mem_access_data = line1;
    tick();
    bus.in_mem_access_valid = 1'b0;
    checks++; if (bus.out_req_read_instr !== 32'hBBBBBBBB)
      $display("FAIL conf_refill got=%h want=bbbbbbbb", bus.out_req_read_instr); else passed++;
    tick();
  endtask

  task automatic test_flush_during_miss();
    bus.in_req_read_req = 1'b1;
    bus.in_req_read_addr = 64'h3024;
    tick();
    bus.in_req_read_req = 1'b0;
    bus.in_flush = 1'b1;
    tick();
    bus.in_flush = 1'b0;
    bus.in_mem_access_valid = 1'b1;
    bus.in_mem_access_data = line3;
    tick();
    bus.in_mem_access_valid = 1'b0;
    checks++; if (bus.out_req_read_valid !== 1'b1 || bus.out_req_read_instr !== 32'hDDDDDDDD)
      $display("FAIL flush_fill got=v%b/%h want=v1/dddddddd", bus.out_req_read_valid,
               bus.out_req_read_instr); else passed++;
    tick();
    checks++; if (bus.out_busy !== 1'b1)
      $display("FAIL flush_busy got=%b want=1", bus.out_busy); else passed++;
    bus.in_req_read_req = 1'b1;
    bus.in_req_read_addr = 64'h3024;
    tick();
    checks++; if (bus.out_busy !== 1'b0 || bus.out_mem_access_req !== 1'b0 ||
                  bus.out_req_read_valid !== 1'b0)
      $display("FAIL flush_drop got=busy%b/req%b/v%b want=0/0/0", bus.out_busy,
               bus.out_mem_access_req, bus.out_req_read_valid); else passed++;
    tick();
    bus.in_req_read_req = 1'b0;
    checks++; if (bus.out_mem_access_req !== 1'b1 || bus.out_mem_access_addr !== 64'h3020)
      $display("FAIL flush_remiss got=req%b/%h want=req1/3020", bus.out_mem_access_req,
               bus.out_mem_access_addr); else passed++;
    bus.in_mem_access_valid = 1'b1;
    bus.in_mem_access_data = line3;
    tick();
    bus.in_mem_access_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_miss();
    int v0;
    bus.in_req_read_req = 1'b1;
    bus.in_req_read_addr = 64'h5000;
    tick();
    bus.in_req_read_req = 1'b0;
    checks++; if (bus.out_mem_access_req !== 1'b1)
      $display("FAIL rstmid_req got=%b want=1", bus.out_mem_access_req); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_mem_access_req !== 1'b0 || bus.out_busy !== 1'b0 ||
                  bus.out_req_read_valid !== 1'b0 || bus.out_req_read_instr !== 32'h0 ||
                  bus.out_mem_access_addr !== 64'h0)
      $display("FAIL rstmid_outs got=req%b/busy%b/v%b/%h/%h want=all0", bus.out_mem_access_req,
               bus.out_busy, bus.out_req_read_valid, bus.out_req_read_instr,
               bus.out_mem_access_addr); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    v0 = vcount;
    bus.in_mem_access_valid = 1'b1;
    bus.in_mem_access_data = line2;
    tick();
    bus.in_mem_access_valid = 1'b0;
    tick();
    tick();
    checks++; if (vcount - v0 !== 0 || bus.out_busy !== 1'b0)
      $display("FAIL rstmid_stray got=pulses%0d/busy%b want=0/0", vcount - v0,
               bus.out_busy); else passed++;
    bus.in_req_read_req = 1'b1;
    bus.in_req_read_addr = 64'h1004;
    tick();
    bus.in_req_read_req = 1'b0;
    checks++; if (bus.out_mem_access_req !== 1'b1)
      $display("FAIL rstmid_cold got=%b want=1", bus.out_mem_access_req); else passed++;
    bus.in_mem_access_valid = 1'b1;
    bus.in_mem_access_data = line1;
    tick();
    bus.in_mem_access_valid = 1'b0;
    tick();
  endtask

`ifdef SNOW64_ICACHE_STATS_EN
  task automatic test_stats();
    do_reset();
    serve_miss(64'h1004, line1);
    bus.in_req_read_req = 1'b1;
    bus.in_req_read_addr = 64'h1000;
    tick();
    tick();
    tick();
    bus.in_req_read_req = 1'b0;
    tick();
    checks++; if (hit_count !== 32'd3 || miss_count !== 32'd1)
      $display("FAIL stats got=%0d/%0d want=3/1", hit_count, miss_count); else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    line1 = mk_line(32'hAAAAAAAA, 32'hBBBBBBBB, 32'h10000000);
    line2 = mk_line(32'h11111111, 32'hCCCCCCCC, 32'h20000000);
    line3 = mk_line(32'h22222222, 32'hDDDDDDDD, 32'h30000000);
    bus.in_req_read_req = 1'b0;
    bus.in_req_read_addr = '0;
    bus.in_flush = 1'b0;
    bus.in_mem_access_valid = 1'b0;
    bus.in_mem_access_data = '0;
    test_reset();
    test_cold_miss();
    test_back_to_back_hits();
    test_conflict();
    test_flush_during_miss();
    test_reset_mid_miss();
`ifdef SNOW64_ICACHE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/snow64_param_instr_cache.md
# snow64_param_instr_cache

Parametrised direct-mapped, read-only instruction cache for the Snow64 CPU. It sits between instruction fetch and the memory arbiter, and generalises the fixed-geometry instruction cache in address width, instruction width, line width and line count. It adds the lookup/miss/fill state machine, a line-aligned memory request handshake, fill-data forwarding and a whole-cache invalidate. Optional hit/miss counters support performance work.

## Interface
Parameters:
- ADDR_WIDTH, 64: byte-address width.
- INSTR_WIDTH, 32: instruction width in bits; power of two, at least 8.
- LINE_WIDTH, 256: line width in bits; power-of-two multiple of INSTR_WIDTH.
- NUM_LINES, 32: number of lines; power of two, at least 2.
- Derived: OFFS = log2(LINE_WIDTH/8), IDX = log2(NUM_LINES), TAG = ADDR_WIDTH-OFFS-IDX. Address fields are tag [ADDR_WIDTH-1:OFFS+IDX], index [OFFS+IDX-1:OFFS], offset [OFFS-1:0].

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_req_read_req  in  1  fetch request.
- in_req_read_addr  in  ADDR_WIDTH  fetch byte address; the low log2(INSTR_WIDTH/8) bits are ignored.
- out_req_read_valid  out  1  one-cycle pulse; the instruction is valid.
- out_req_read_instr  out  INSTR_WIDTH  fetched instruction.
- out_busy  out  1  high when not in IDLE; requests are not accepted.
- in_flush  in  1  invalidate all lines.
- out_mem_access_req  out  1  line fill request.
- out_mem_access_addr  out  ADDR_WIDTH  line-aligned fill address; offset bits are 0.
- in_mem_access_valid  in  1  fill data present, one-cycle pulse.
- in_mem_access_data  in  LINE_WIDTH  fill line; the instruction at offset 0 is in the LSBs.
- out_hit_count, out_miss_count  out  32 each  exist only with SNOW64_ICACHE_STATS_EN.

## Operation
- Storage: data, tag and valid arrays, NUM_LINES entries each. Only the valid flags are reset.
- The FSM has three states: IDLE, MISS_REQ and FILL.
- IDLE, with in_flush high: clear all valid flags in one cycle and stay in IDLE. in_flush wins over a same-cycle request, which is dropped.
- IDLE, with a request and no flush: on a hit (valid and tag match), register the selected instruction and pulse valid. On a miss, latch the address and go to MISS_REQ.
- MISS_REQ: drive out_mem_access_req=1 with the latched line address. Hold both until in_mem_access_valid, then go to FILL.
- The cycle in_mem_access_valid is seen: write the line, write the tag and set the valid flag.
- FILL (one cycle): the forwarded instruction from the fill data is output with a valid pulse, then go to IDLE.
- in_flush outside IDLE sets flush_pending. The flush runs on the IDLE entry cycle, after the miss response, and that cycle's request is dropped. out_busy stays high for that cycle.
- in_mem_access_valid outside MISS_REQ is ignored.
- Requests while out_busy=1 are ignored; the requester holds or retries.
- A conflicting fill overwrites the previous line at that index.

## Timing
- Reset values: valid, mem req and busy are 0, instr is 0, the address output is 0, counters are 0, the FSM is in IDLE, all valid flags are 0 and flush_pending is 0.
- Hit: request at edge N produces valid and instr at N+1; back-to-back hits give one per cycle.
- Miss: request at N raises mem req at N+1. Memory valid at M gives the cache write and the FILL state at M+1, with out valid at M+1 and IDLE at M+2.
- out_req_read_instr holds its last value between pulses.
- rst_n low mid-miss: the request is dropped at once, no fill and no valid pulse occur, and a later memory valid is ignored.

## Configuration
- SNOW64_ICACHE_STATS_EN defined: the counters exist. A hit increments hit_count in the request cycle; a miss increments miss_count on the MISS_REQ entry. They wrap at 2^32, reset to 0 and are not cleared by flush.
- SNOW64_ICACHE_STATS_EN undefined: no counter ports and no logic.

## Test plan
- Cold miss: read 0x1004, memory returns line {..., 0xBBBBBBBB, 0xAAAAAAAA} after 3 cycles. Required: mem addr 0x1000, out instr 0xBBBBBBBB, valid pulses once.
- Hit: repeat 0x1004 then 0x1000 back-to-back. Required: 0xBBBBBBBB then 0xAAAAAAAA on consecutive cycles, and no mem req.
- Conflict: read 0x1404 (index 0, new tag). Required: miss, mem addr 0x1400; a following read of 0x1004 misses again.
- Flush during miss: in_flush pulses in MISS_REQ. Required: the fill response is delivered, then a read of the same address misses.
- Reset mid-miss: rst_n low while mem req is high. Required: all outputs are 0 immediately; a stray memory valid after reset gives no valid pulse.
- Stats (macro on): 1 miss then 3 hits. Required: hit_count=3, miss_count=1.
